mskaes_128bits_round_fsm: RTL and testbench
===========================================

# mskaes_128bits_round_fsm

Round sequencer for the 128-bit masked AES core. It sits directly upstream of the RCON delay pipeline. It accepts an encryption request through a valid/ready handshake and steps through 10 rounds of LATENCY cycles each, which is the pipeline depth of the masked S-box layer. It drives the pipeline's `RCON_in` and closes the round-constant loop by feeding the pipeline's `RCON_out` back in. It also issues the datapath strobes: load, round end and last round.

## Interface
Parameters:
- `LATENCY`, default 4: cycles per round; equals the S-box pipeline depth and the LATENCY of the companion RCON pipeline. Legal range is ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: request to start an encryption.
- `in_ready`, out, 1: block can accept a request.
- `out_valid`, out, 1: ciphertext in datapath is final.
- `out_ready`, in, 1: consumer takes the result.
- `rcon_next`, in, 8: the RCON pipeline's `RCON_out`.
- `rcon_in`, out, 8: drives the RCON pipeline's `RCON_in`.
- `load`, out, 1: datapath captures plaintext/key shares this cycle.
- `round_end`, out, 1: datapath state registers capture the round result this cycle.
- `last_round`, out, 1: current round is 10; MixColumns bypassed.
- `round`, out, 4: current round number, 1..10; 0 when not running.
- `busy`, out, 1: in ROUND state; randomness consumed every busy cycle.

## Operation
- The FSM has three states: IDLE, ROUND and DONE.
- Internal counters:
  - `round` is 4 bits.
  - `cnt` is max(1, clog2(LATENCY)) bits and runs 0..LATENCY-1.
- IDLE:
  - `in_ready`=1 (and `rst` is low).
  - On `in_valid && in_ready`: assert `load` (combinational, in that cycle); next state is ROUND with `round`=1 and `cnt`=0.
- ROUND:
  - `cnt` increments every cycle.
  - `round_end` = (`cnt`==LATENCY-1).
  - At `round_end` with `round`<10: `cnt`←0 and `round`←`round`+1.
  - At `round_end` with `round`==10: next state is DONE and `round`←0.
- DONE:
  - `out_valid`=1, held stable until `out_ready`.
  - On `out_ready`: next state is IDLE.
  - No new request is accepted in DONE; `in_ready`=0.
- `rcon_in`:
  - 8'h01 when in IDLE, DONE, or ROUND with `round`==1.
  - Otherwise `rcon_next`.
- Resulting constant schedule: with the companion pipeline of equal LATENCY, `rcon_in` equals RC[r] on every cycle of round r. The sequence is 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36; the wrap through 0x1B comes from the pipeline's xtime reduction.
- `last_round` = ROUND && `round`==10.
- `busy` = ROUND.
- `in_valid` outside IDLE is ignored and is not queued.

## Timing
- Reset values (asserted asynchronously): state IDLE, `round`=0, `cnt`=0, `out_valid`=0, `load`=0, `round_end`=0, `last_round`=0, `busy`=0, `rcon_in`=8'h01.
- `in_ready`=0 while `rst` is high; it is 1 from the first cycle after deassertion.
- Accept at cycle T:
  - Round r occupies cycles T+1+(r-1)·LATENCY .. T+r·LATENCY.
  - `round_end` pulses at T+r·LATENCY.
  - `out_valid` first asserts at T+10·LATENCY+1.
- Minimum request-to-request spacing is 10·LATENCY+2 cycles (with `out_ready` tied high); no back-to-back acceptance.
- Boundary behaviour:
  - LATENCY=1: `round_end` is high on every ROUND cycle.
  - `rst` mid-operation: immediate return to IDLE with all outputs at reset values; the partial result is discarded and no `out_valid` is produced.
  - `out_ready` high in the same cycle `out_valid` first rises: handshake completes and the block is in IDLE the next cycle.
  - `in_valid` and `out_ready` high together in DONE: only the output handshake completes.

## Test plan
- Reset, then LATENCY=4 with `in_valid` pulsed at T=5 and `out_ready`=1 → `load` at 5; `round_end` at 9, 13, …, 45; `last_round` over 42..45; `out_valid` at 46; `in_ready` at 47.
- RCON loop closed through the companion pipeline, LATENCY=4 and LATENCY=1 → `rcon_in` sampled during each round equals 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- `out_ready` held low for 7 cycles after `out_valid` → `out_valid` stays high for 8 cycles, `in_ready`=0 throughout, and `in_valid` pulses in that window are ignored.
- `rst` asserted asynchronously mid-round 6 → `busy`, `round`, `last_round` and `out_valid` go to 0 immediately and `rcon_in`=01; the next request runs the full 10 rounds.
- `in_valid` asserted during ROUND at round 3 → no restart, round count unaffected, single `out_valid`.
- LATENCY=1 → `round_end` high for 10 consecutive cycles and `out_valid` 11 cycles after accept.

Source files
------------

// File: rtl/mskaes_128bits_round_fsm.sv
// Round sequencer for the 128-bit masked AES core: runs 10 rounds of LATENCY
// cycles each and closes the round-constant loop through the RCON pipeline.
module mskaes_128bits_round_fsm #(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] rcon_next,
  output logic [7:0] rcon_in,
  output logic       load,
  output logic       round_end,
  output logic       last_round,
  output logic [3:0] round,
  output logic       busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= 4'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= ROUND;
            round <= 4'd1;
            cnt   <= '0;
          end
        end
        ROUND: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (round == LAST_ROUND) begin
              state <= DONE;
              round <= 4'd0;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // a request arriving together with out_ready is deliberately dropped
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE) && !rst;
  assign load       = in_ready && in_valid;
  assign busy       = (state == ROUND);
  assign round_end  = busy && (cnt == CNT_LAST);
  assign last_round = busy && (round == LAST_ROUND);
  assign out_valid  = (state == DONE);
  // round 1 seeds the loop; later rounds reuse the pipeline's xtime'd constant
  assign rcon_in    = (!busy || round == 4'd1) ? 8'h01 : rcon_next;

endmodule

// File: tb/tb_mskaes_128bits_round_fsm.sv
// Bench for the round sequencer: two instances (LATENCY 4 and 1), each with a
// behavioural RCON delay pipeline closing the constant loop.
module tb_mskaes_128bits_round_fsm;

  localparam int LA = 4;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic sel_b = 1'b0;

  logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic       a_in_ready, a_out_valid, a_load, a_round_end, a_last_round, a_busy;
  logic [3:0] a_round;
  logic [7:0] a_rcon_in, a_rcon_next;

  logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic       b_in_ready, b_out_valid, b_load, b_round_end, b_last_round, b_busy;
  logic [3:0] b_round;
  logic [7:0] b_rcon_in, b_rcon_next;

  mskaes_128bits_round_fsm #(.LATENCY(LA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .rcon_next(a_rcon_next),
    .rcon_in(a_rcon_in), .load(a_load), .round_end(a_round_end),
    .last_round(a_last_round), .round(a_round), .busy(a_busy)
  );

  mskaes_128bits_round_fsm #(.LATENCY(LB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .rcon_next(b_rcon_next),
    .rcon_in(b_rcon_in), .load(b_load), .round_end(b_round_end),
    .last_round(b_last_round), .round(b_round), .busy(b_busy)
  );

  // Companion RCON pipelines: xtime on entry, then LATENCY register stages.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] pa [LA];
  logic [7:0] pb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LA; i++) pa[i] <= 8'h00;
      pb <= 8'h00;
    end else begin
      pa[0] <= xtime(a_rcon_in);
      for (int i = 1; i < LA; i++) pa[i] <= pa[i-1];
      pb <= xtime(b_rcon_in);
    end
  end
  assign a_rcon_next = pa[LA-1];
  assign b_rcon_next = pb;

  // {round, round_end, last_round, busy, in_ready, out_valid, load}
  logic [9:0] a_ctl, b_ctl, obs_ctl;
  logic [7:0] obs_rcon;
  assign a_ctl    = {a_round, a_round_end, a_last_round, a_busy, a_in_ready, a_out_valid, a_load};
  assign b_ctl    = {b_round, b_round_end, b_last_round, b_busy, b_in_ready, b_out_valid, b_load};
  assign obs_ctl  = sel_b ? b_ctl : a_ctl;
  assign obs_rcon = sel_b ? b_rcon_in : a_rcon_in;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy);
    a_in_valid  = !sel_b && iv;
    a_out_ready = !sel_b && ordy;
    b_in_valid  = sel_b && iv;
    b_out_ready = sel_b && ordy;
  endtask

  function automatic logic [7:0] rc_of(input int r);
    if (r <= 8) return 8'(1 << (r - 1));
    return (r == 9) ? 8'h1b : 8'h36;
  endfunction

  // One encryption: accept, 10 rounds, DONE held for `hold` cycles before out_ready.
  // abort_at > 0 asserts rst asynchronously inside that busy cycle and returns.
  task automatic txn(input logic sel, input int hold, input int abort_at, input string tag);
    int lat;
    int r;
    logic [9:0] ectl;
    logic [7:0] erc;
    sel_b = sel;
    lat = sel ? LB : LA;
    step();
    drive(1'b1, 1'($urandom));
    @(negedge clk);
    n_cmp++;
    if (obs_ctl !== 10'b0000_0001_01) begin
      n_err++;
      $display("FAIL %s accept: ctl got %b want %b", tag, obs_ctl, 10'b0000_0001_01);
    end
    for (int c = 1; c <= 10 * lat; c++) begin
      r = (c - 1) / lat + 1;
      step();
      drive((r == 3) ? 1'b1 : 1'($urandom), 1'($urandom));
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_ctl !== 10'd0 || obs_rcon !== 8'h01) begin
          n_err++;
          $display("FAIL %s async_reset: ctl got %b want %b, rcon got %h want 01",
                   tag, obs_ctl, 10'd0, obs_rcon);
        end
        return;
      end
      @(negedge clk);
      ectl = {4'(r), (c % lat == 0), (r == 10), 1'b1, 1'b0, 1'b0, 1'b0};
      erc  = rc_of(r);
      n_cmp++;
      if (obs_ctl !== ectl) begin
        n_err++;
        $display("FAIL %s round_ctl c=%0d: got %b want %b", tag, c, obs_ctl, ectl);
      end
      n_cmp++;
      if (obs_rcon !== erc) begin
        n_err++;
        $display("FAIL %s rcon c=%0d round=%0d: got %h want %h", tag, c, r, obs_rcon, erc);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      step();
      drive((h == hold) ? 1'b1 : 1'($urandom), (h == hold));
      @(negedge clk);
      n_cmp++;
      if (obs_ctl !== 10'b0000_0000_10 || obs_rcon !== 8'h01) begin
        n_err++;
        $display("FAIL %s done h=%0d: ctl got %b want %b, rcon got %h want 01",
                 tag, h, obs_ctl, 10'b0000_0000_10, obs_rcon);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (a_ctl !== 10'd0 || b_ctl !== 10'd0 || a_rcon_in !== 8'h01 || b_rcon_in !== 8'h01) begin
      n_err++;
      $display("FAIL reset_values: a %b b %b rcon %h/%h want all zero, rcon 01",
               a_ctl, b_ctl, a_rcon_in, b_rcon_in);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_ctl !== 10'b0000_0001_00 || b_ctl !== 10'b0000_0001_00) begin
      n_err++;
      $display("FAIL reset_release: a %b b %b want %b", a_ctl, b_ctl, 10'b0000_0001_00);
    end
  endtask

  task automatic test_latency4_basic();
    txn(1'b0, 0, 0, "lat4_basic");
  endtask

  task automatic test_out_ready_hold();
    txn(1'b0, 7, 0, "lat4_hold7");
  endtask

  task automatic test_back_to_back();
    txn(1'b0, 0, 0, "b2b_first");
    txn(1'b0, 2, 0, "b2b_second");
  endtask

  task automatic test_midround_reset();
    txn(1'b0, 0, 5 * LA + 2, "mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    txn(1'b0, 1, 0, "after_reset");
  endtask

  task automatic test_latency1();
    txn(1'b1, 0, 0, "lat1_basic");
    txn(1'b1, 3, 0, "lat1_hold3");
  endtask

  task automatic test_idle_after();
    sel_b = 1'b0;
    step();
    drive(1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (a_ctl !== 10'b0000_0001_00 || b_ctl !== 10'b0000_0001_00) begin
      n_err++;
      $display("FAIL idle_after: a %b b %b want %b", a_ctl, b_ctl, 10'b0000_0001_00);
    end
  endtask

  initial begin
    test_reset();
    test_latency4_basic();
    test_out_ready_hold();
    test_back_to_back();
    test_midround_reset();
    test_latency1();
    test_idle_after();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
